// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC engine with a single outstanding request to a
// variable-latency ROM, a prefetch queue toward decode and a flushing redirect port.
module fetch_unit #(
  parameter int                SIZE         = 32,
  parameter int                ADDR_WIDTH   = 10,
  parameter int                DEPTH        = 2,
  parameter logic [SIZE-1:0]   RESET_VECTOR = '0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  output logic                  ROM_REQ,
  output logic [ADDR_WIDTH-1:0] ADDR_ROM,
  input  logic                  ROM_VALID,
  input  logic [SIZE-1:0]       Q_ROM,
  input  logic                  REDIRECT,
  input  logic [SIZE-1:0]       REDIRECT_PC,
  input  logic                  IF_READY,
  output logic                  IF_VALID,
  output logic [SIZE-1:0]       IF_INST,
  output logic [SIZE-1:0]       IF_PC,
  output logic [SIZE-1:0]       IF_PC_PLUS4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t          state;
  logic [SIZE-1:0] fetch_pc;
  logic [SIZE-1:0] req_pc;
  logic [SIZE-1:0] inst_q [DEPTH];
  logic [SIZE-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ_next;
  logic            has_room;
  logic            unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign IF_VALID = (count != '0);
  assign pop      = IF_VALID & IF_READY;
  assign push     = ROM_VALID & (state == S_WAIT);

  // Occupancy after this cycle's push/pop; a new request needs a slot reserved for its reply.
  assign occ_next = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
  assign has_room = (occ_next < DEPTH_OCC);

  assign issue   = !REDIRECT & has_room &
                   ((state == S_IDLE) | ((state == S_WAIT) & ROM_VALID));
  assign ROM_REQ = issue & RESET_N;

  assign ADDR_ROM    = fetch_pc[ADDR_WIDTH+1:2];
  assign IF_INST     = inst_q[rd_ptr];
  assign IF_PC       = pc_q[rd_ptr];
  assign IF_PC_PLUS4 = IF_PC + SIZE'(4);

  // Target low bits are forced to zero; the incoming ones carry no meaning.
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // NOTE: all state here is sequential, so every assignment is non-blocking to
  // keep reads of the old value consistent across the block.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_VECTOR;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // NOTE: the queue storage is reset too, because the head entry drives
      // IF_INST/IF_PC directly and must read as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (REDIRECT) begin
      fetch_pc <= {REDIRECT_PC[SIZE-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A request still in flight must have its reply swallowed.
      if (state == S_WAIT) begin
        state <= ROM_VALID ? S_IDLE : S_DISCARD;
      end
    end else begin
      if (push) begin
        inst_q[wr_ptr] <= Q_ROM;
        pc_q[wr_ptr]   <= req_pc;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= CW'(occ_next);

      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + SIZE'(4);
      end

      unique case (state)
        S_IDLE: begin
          if (issue) state <= S_WAIT;
        end
        S_WAIT: begin
          if (ROM_VALID) state <= issue ? S_WAIT : S_IDLE;
        end
        S_DISCARD: begin
          if (ROM_VALID) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM with programmable latency and
// hand-computed expectations for reset, streaming, backpressure, redirect and wrap.
module tb_fetch_unit;

  localparam int SIZE  = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 2;

  logic            CLK;
  logic            RESET_N;
  logic            ROM_REQ;
  logic [AW-1:0]   ADDR_ROM;
  logic            ROM_VALID;
  logic [SIZE-1:0] Q_ROM;
  logic            REDIRECT;
  logic [SIZE-1:0] REDIRECT_PC;
  logic            IF_READY;
  logic            IF_VALID;
  logic [SIZE-1:0] IF_INST;
  logic [SIZE-1:0] IF_PC;
  logic [SIZE-1:0] IF_PC_PLUS4;

  int checks   = 0;
  int failures = 0;

  int rom_lat   = 1;
  int kill_req  = 0;
  int kill_ack  = 0;
  int stray_req = 0;
  int stray_ack = 0;

  fetch_unit #(
    .SIZE(SIZE), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ROM_REQ(ROM_REQ), .ADDR_ROM(ADDR_ROM),
    .ROM_VALID(ROM_VALID), .Q_ROM(Q_ROM),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IF_READY(IF_READY), .IF_VALID(IF_VALID),
    .IF_INST(IF_INST), .IF_PC(IF_PC), .IF_PC_PLUS4(IF_PC_PLUS4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM model: word n holds 0x1000+n; reply rom_lat cycles after the request.
  // Responses change 1 unit after the edge, requests are sampled 4 units after it.
  initial begin
    bit            pending;
    bit            req_seen;
    int            cnt;
    logic [AW-1:0] paddr;
    logic [AW-1:0] saddr;
    pending   = 1'b0;
    req_seen  = 1'b0;
    cnt       = 0;
    paddr     = '0;
    saddr     = '0;
    ROM_VALID = 1'b0;
    Q_ROM     = '0;
    forever begin
      @(posedge CLK);
      #1;
      ROM_VALID = 1'b0;
      if (kill_req != kill_ack) begin
        kill_ack = kill_req;
        pending  = 1'b0;
        req_seen = 1'b0;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        ROM_VALID = 1'b1;
        Q_ROM     = 32'hDEAD_BEEF;
        pending   = 1'b0;
        req_seen  = 1'b0;
      end else begin
        if (req_seen) begin
          pending  = 1'b1;
          cnt      = rom_lat;
          paddr    = saddr;
          req_seen = 1'b0;
        end
        if (pending) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            ROM_VALID = 1'b1;
            Q_ROM     = 32'h1000 + 32'(paddr);
            pending   = 1'b0;
          end
        end
      end
      #3;
      req_seen = ROM_REQ;
      saddr    = ADDR_ROM;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance to the drive point of the next cycle (2 units after the rising edge).
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_req"},  32'(ROM_REQ),  32'd0);
    chk({tag, "_if_valid"}, 32'(IF_VALID), 32'd0);
    chk({tag, "_if_inst"},  IF_INST,       32'h0);
    chk({tag, "_if_pc"},    IF_PC,         32'h0);
    chk({tag, "_pc_plus4"}, IF_PC_PLUS4,   32'h4);
    chk({tag, "_addr"},     32'(ADDR_ROM), 32'd0);
  endtask

  // Pulse reset across one edge and discard anything the ROM still holds.
  task automatic do_reset();
    cyc();
    RESET_N  = 1'b0;
    kill_req = kill_req + 1;
    cyc();
    RESET_N = 1'b1;
    #1;
  endtask

  initial begin
    RESET_N     = 1'b0;
    IF_READY    = 1'b1;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    rom_lat     = 1;

    // Reset values, then streaming at L=1.
    #3;
    chk_reset_outputs("rst");
    cyc();
    RESET_N = 1'b1;
    #1;
    chk("s0_req",   32'(ROM_REQ),  32'd1);
    chk("s0_addr",  32'(ADDR_ROM), 32'd0);
    chk("s0_valid", 32'(IF_VALID), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      #1;
      chk("s_req",  32'(ROM_REQ),  32'd1);
      chk("s_addr", 32'(ADDR_ROM), 32'(i));
      if (i < 2) begin
        chk("s_valid", 32'(IF_VALID), 32'd0);
      end else begin
        chk("s_valid", 32'(IF_VALID), 32'd1);
        chk("s_pc",    IF_PC,         32'(4 * (i - 2)));
        chk("s_inst",  IF_INST,       32'h1000 + 32'(i - 2));
        chk("s_plus4", IF_PC_PLUS4,   32'(4 * (i - 2) + 4));
      end
    end

    // Backpressure: two requests fill the queue, then a gap-free drain.
    IF_READY = 1'b0;
    do_reset();
    chk("bp0_req",  32'(ROM_REQ),  32'd1);
    chk("bp0_addr", 32'(ADDR_ROM), 32'd0);
    cyc(); #1;
    chk("bp1_req",  32'(ROM_REQ),  32'd1);
    chk("bp1_addr", 32'(ADDR_ROM), 32'd1);
    cyc(); #1;
    chk("bp2_req",   32'(ROM_REQ),  32'd0);
    chk("bp2_valid", 32'(IF_VALID), 32'd1);
    chk("bp2_pc",    IF_PC,         32'h0);
    cyc(); #1;
    chk("bp3_full_req", 32'(ROM_REQ), 32'd0);
    chk("bp3_pc",       IF_PC,        32'h0);
    cyc();
    IF_READY = 1'b1;
    #1;
    chk("bp4_req",  32'(ROM_REQ),  32'd1);
    chk("bp4_addr", 32'(ADDR_ROM), 32'd2);
    chk("bp4_pc",   IF_PC,         32'h0);
    chk("bp4_inst", IF_INST,       32'h1000);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      chk("bp_drain_valid", 32'(IF_VALID), 32'd1);
      chk("bp_drain_pc",    IF_PC,         32'(4 * k));
      chk("bp_drain_inst",  IF_INST,       32'h1000 + 32'(k));
    end

    // Redirect while a 3-cycle request is outstanding.
    rom_lat = 3;
    do_reset();
    chk("rd0_req", 32'(ROM_REQ), 32'd1);
    cyc();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h40;
    #1;
    chk("rd1_req", 32'(ROM_REQ), 32'd0);
    cyc();
    REDIRECT = 1'b0;
    #1;
    chk("rd2_req",   32'(ROM_REQ),  32'd0);
    chk("rd2_valid", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("rd3_discard_req", 32'(ROM_REQ), 32'd0);
    cyc(); #1;
    chk("rd4_req",   32'(ROM_REQ),  32'd1);
    chk("rd4_addr",  32'(ADDR_ROM), 32'h10);
    chk("rd4_valid", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("rd5_dropped_valid", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("rd6_valid", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("rd7_req",  32'(ROM_REQ),  32'd1);
    chk("rd7_addr", 32'(ADDR_ROM), 32'h11);
    cyc();
    IF_READY = 1'b0;
    #1;
    chk("rd8_valid", 32'(IF_VALID), 32'd1);
    chk("rd8_pc",    IF_PC,         32'h40);
    chk("rd8_inst",  IF_INST,       32'h1010);

    // Redirect coinciding with ROM_VALID and a pop: flush wins, reply dropped.
    cyc(); #1;
    chk("rv9_req", 32'(ROM_REQ), 32'd0);
    chk("rv9_pc",  IF_PC,        32'h40);
    cyc();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h83;
    IF_READY    = 1'b1;
    #1;
    chk("rv10_req",   32'(ROM_REQ),  32'd0);
    chk("rv10_valid", 32'(IF_VALID), 32'd1);
    cyc();
    REDIRECT = 1'b0;
    rom_lat  = 1;
    #1;
    chk("rv11_flush_valid", 32'(IF_VALID), 32'd0);
    chk("rv11_req",         32'(ROM_REQ),  32'd1);
    chk("rv11_addr",        32'(ADDR_ROM), 32'h20);
    cyc(); #1;
    chk("rv12_valid", 32'(IF_VALID), 32'd0);
    chk("rv12_addr",  32'(ADDR_ROM), 32'h21);
    cyc(); #1;
    chk("rv13_valid", 32'(IF_VALID), 32'd1);
    chk("rv13_pc",    IF_PC,         32'h80);
    chk("rv13_inst",  IF_INST,       32'h1020);

    // ROM address wrap from the top word back to word 0.
    cyc();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFF8;
    #1;
    chk("aw_redirect_req", 32'(ROM_REQ), 32'd0);
    cyc();
    REDIRECT = 1'b0;
    #1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        cyc(); #1;
      end
      chk("aw_req",  32'(ROM_REQ),  32'd1);
      chk("aw_addr", 32'(ADDR_ROM), 32'((1022 + k) % 1024));
      if (k < 2) begin
        chk("aw_valid", 32'(IF_VALID), 32'd0);
      end else begin
        chk("aw_pc",   IF_PC,   32'hFF8 + 32'(4 * (k - 2)));
        chk("aw_inst", IF_INST, 32'h1000 + 32'((1020 + k) % 1024));
      end
    end

    // Full PC wrap; low target bits ignored.
    cyc();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFF;
    #1;
    chk("pw_redirect_req", 32'(ROM_REQ), 32'd0);
    cyc();
    REDIRECT = 1'b0;
    #1;
    chk("pw_addr0",  32'(ADDR_ROM), 32'd1023);
    chk("pw_valid0", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("pw_addr1", 32'(ADDR_ROM), 32'd0);
    cyc(); #1;
    chk("pw_pc",    IF_PC,       32'hFFFF_FFFC);
    chk("pw_plus4", IF_PC_PLUS4, 32'h0);
    chk("pw_inst",  IF_INST,     32'h13FF);
    cyc();
    rom_lat = 3;
    #1;
    chk("pw_pc_next", IF_PC,       32'h0);
    chk("pw_plus4_n", IF_PC_PLUS4, 32'h4);
    cyc(); #1;
    chk("pre_rst_valid", 32'(IF_VALID), 32'd1);
    chk("pre_rst_pc",    IF_PC,         32'h4);
    chk("pre_rst_req",   32'(ROM_REQ),  32'd0);

    // Reset during WAIT; a stray reply in the first cycle after release is ignored.
    cyc();
    RESET_N   = 1'b0;
    stray_req = stray_req + 1;
    #1;
    chk_reset_outputs("mid_rst");
    cyc();
    RESET_N = 1'b1;
    rom_lat = 1;
    #1;
    chk("post_rst_req",   32'(ROM_REQ),  32'd1);
    chk("post_rst_addr",  32'(ADDR_ROM), 32'd0);
    chk("post_rst_valid", 32'(IF_VALID), 32'd0);
    cyc(); #1;
    chk("stray_ignored_valid", 32'(IF_VALID), 32'd0);
    chk("post_rst_addr1",      32'(ADDR_ROM), 32'd1);
    cyc(); #1;
    chk("restart_valid", 32'(IF_VALID), 32'd1);
    chk("restart_pc",    IF_PC,         32'h0);
    chk("restart_inst",  IF_INST,       32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
